// File: rtl/fetch_stage_pkg.sv
// Shared defaults for the instruction-fetch stage: widths, increment,
// reset PC and the NOP encoding used for empty IF/ID slots.
package fetch_stage_pkg;

    localparam int DEF_DW  = 5;
    localparam int DEF_IW  = 32;
    localparam int DEF_INC = 1;

    localparam logic [DEF_DW-1:0] DEF_RESET_PC = '0;
    localparam logic [DEF_IW-1:0] DEF_NOP      = '0;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The slave side is the fetch stage itself; the master side is everything
// around it (hazard unit, branch resolution, instruction memory, decode).
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int IW = DEF_IW
);

    logic          Stall;
    logic          Redirect;
    logic [DW-1:0] RedirectPc;
    logic [DW-1:0] ImemAddr;
    logic [IW-1:0] ImemData;
    logic [IW-1:0] IfIdInstr;
    logic [DW-1:0] IfIdPc;
    logic [DW-1:0] IfIdPcPlus;
    logic          IfIdValid;

    modport slave (
        input  Stall, Redirect, RedirectPc, ImemData,
        output ImemAddr, IfIdInstr, IfIdPc, IfIdPcPlus, IfIdValid
    );

    modport master (
        output Stall, Redirect, RedirectPc, ImemData,
        input  ImemAddr, IfIdInstr, IfIdPc, IfIdPcPlus, IfIdValid
    );

endinterface

// File: rtl/fetch_stage_adder.sv
// Plain DW-bit adder; the carry out is dropped so results wrap modulo 2^DW.
module Adder #(
    parameter int DW = 5
) (
    input  logic [DW-1:0] AddIn1,
    input  logic [DW-1:0] AddIn2,
    output logic [DW-1:0] AddOut
);

    assign AddOut = AddIn1 + AddIn2;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Redirect beats Stall beats normal sequential fetch on every edge.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              DW       = DEF_DW,
    parameter int              IW       = DEF_IW,
    parameter int              INC      = DEF_INC,
    parameter logic [DW-1:0]   RESET_PC = DEF_RESET_PC,
    parameter logic [IW-1:0]   NOP      = DEF_NOP
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.slave   bus
);

    logic [DW-1:0] pc;
    logic [DW-1:0] pcPlus;
    logic [IW-1:0] ifIdInstr;
    logic [DW-1:0] ifIdPc;
    logic [DW-1:0] ifIdPcPlus;
    logic          ifIdValid;

    Adder #(
        .DW (DW)
    ) pcAdder (
        .AddIn1 (pc),
        .AddIn2 (DW'(INC)),
        .AddOut (pcPlus)
    );

    assign bus.ImemAddr   = pc;
    assign bus.IfIdInstr  = ifIdInstr;
    assign bus.IfIdPc     = ifIdPc;
    assign bus.IfIdPcPlus = ifIdPcPlus;
    assign bus.IfIdValid  = ifIdValid;

    // PC register: jump to the redirect target, hold on stall, else step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.Redirect) begin
            pc <= bus.RedirectPc;
        end else if (!bus.Stall) begin
            pc <= pcPlus;
        end
    end

    // IF/ID register: squash on redirect, freeze on stall, else capture fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifIdInstr  <= NOP;
            ifIdPc     <= '0;
            ifIdPcPlus <= '0;
            ifIdValid  <= 1'b0;
        end else if (bus.Redirect) begin
            ifIdInstr  <= NOP;
            ifIdPc     <= '0;
            ifIdPcPlus <= '0;
            ifIdValid  <= 1'b0;
        end else if (!bus.Stall) begin
            ifIdInstr  <= bus.ImemData;
            ifIdPc     <= pc;
            ifIdPcPlus <= pcPlus;
            ifIdValid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// stall/redirect/reset traffic, all compared against a behavioural model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int PCMOD = 1 << DEF_DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [DEF_IW-1:0] imem [PCMOD];

    int          mPc;
    logic        mValid;
    logic [31:0] mInstr;
    int          mSlotPc;
    int          mSlotPcPlus;

    fetch_stage_if fif ();

    assign fif.ImemData = imem[fif.ImemAddr];

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fif.slave)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".addr"},   32'(fif.ImemAddr),   32'(mPc));
        checkOutput({tag, ".instr"},  32'(fif.IfIdInstr),  mInstr);
        checkOutput({tag, ".pc"},     32'(fif.IfIdPc),     32'(mSlotPc));
        checkOutput({tag, ".pcplus"}, 32'(fif.IfIdPcPlus), 32'(mSlotPcPlus));
        checkOutput({tag, ".valid"},  32'(fif.IfIdValid),  32'(mValid));
    endtask

    task automatic modelReset();
        mPc         = int'(DEF_RESET_PC);
        mValid      = 1'b0;
        mInstr      = 32'(DEF_NOP);
        mSlotPc     = 0;
        mSlotPcPlus = 0;
    endtask

    task automatic modelEdge(input logic stall, input logic redirect, input int target);
        if (redirect) begin
            mPc         = target % PCMOD;
            mValid      = 1'b0;
            mInstr      = 32'(DEF_NOP);
            mSlotPc     = 0;
            mSlotPcPlus = 0;
        end else if (!stall) begin
            mInstr      = 32'(imem[mPc]);
            mSlotPc     = mPc;
            mSlotPcPlus = (mPc + DEF_INC) % PCMOD;
            mValid      = 1'b1;
            mPc         = mSlotPcPlus;
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic redirect,
                                 input int target, input string tag);
        fif.Stall      = stall;
        fif.Redirect   = redirect;
        fif.RedirectPc = DEF_DW'(target);
        @(posedge clk);
        modelEdge(stall, redirect, target);
        #1;
        checkAll(tag);
    endtask

    task automatic doAsyncReset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, ".immAddr"},  32'(fif.ImemAddr),  32'(DEF_RESET_PC));
        checkOutput({tag, ".immValid"}, 32'(fif.IfIdValid), 32'd0);
        checkOutput({tag, ".immInstr"}, 32'(fif.IfIdInstr), 32'(DEF_NOP));
        @(negedge clk);
        @(negedge clk);
        checkAll({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        fif.Stall      = 1'b0;
        fif.Redirect   = 1'b0;
        fif.RedirectPc = '0;
        for (int i = 0; i < PCMOD; i++) imem[i] = 32'h1000 + 32'(i);
        modelReset();

        #1;
        checkAll("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run from reset
        applyStimulus(1'b0, 1'b0, 0, "free1");
        checkOutput("free1.pcConst", 32'(fif.IfIdPc), 32'd0);
        checkOutput("free1.instrConst", 32'(fif.IfIdInstr), 32'h1000);
        applyStimulus(1'b0, 1'b0, 0, "free2");
        applyStimulus(1'b0, 1'b0, 0, "free3");
        checkOutput("free3.pcConst", 32'(fif.IfIdPc), 32'd2);
        checkOutput("free3.pcPlusConst", 32'(fif.IfIdPcPlus), 32'd3);

        // Wrap-around through 31 -> 0
        applyStimulus(1'b0, 1'b1, 30, "wrapRedir");
        applyStimulus(1'b0, 1'b0, 0, "wrap1");
        applyStimulus(1'b0, 1'b0, 0, "wrap2");
        checkOutput("wrap2.addrConst", 32'(fif.ImemAddr), 32'd0);
        applyStimulus(1'b0, 1'b0, 0, "wrap3");
        checkOutput("wrap3.pcConst", 32'(fif.IfIdPc), 32'd0);
        checkOutput("wrap3.addrConst", 32'(fif.ImemAddr), 32'd1);

        // Stall three cycles at PC = 5
        applyStimulus(1'b0, 1'b1, 4, "stallSetup");
        applyStimulus(1'b0, 1'b0, 0, "stallPrime");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 0, "stallHold");
            checkOutput("stallHold.addrConst", 32'(fif.ImemAddr), 32'd5);
            checkOutput("stallHold.pcConst", 32'(fif.IfIdPc), 32'd4);
        end
        applyStimulus(1'b0, 1'b0, 0, "stallRelease");
        checkOutput("stallRelease.pcConst", 32'(fif.IfIdPc), 32'd5);

        // Redirect with stall, then repeated redirect+stall
        applyStimulus(1'b1, 1'b1, 17, "redirStall");
        checkOutput("redirStall.addrConst", 32'(fif.ImemAddr), 32'd17);
        applyStimulus(1'b0, 1'b0, 0, "redirStallNext");
        checkOutput("redirStallNext.pcConst", 32'(fif.IfIdPc), 32'd17);
        applyStimulus(1'b1, 1'b1, 3, "bothA");
        applyStimulus(1'b1, 1'b1, 20, "bothB");
        applyStimulus(1'b1, 1'b1, 11, "bothC");

        // Back-to-back redirects 9 then 12
        applyStimulus(1'b0, 1'b1, 9, "b2b9");
        applyStimulus(1'b0, 1'b1, 12, "b2b12");
        applyStimulus(1'b0, 1'b0, 0, "b2bNext");
        checkOutput("b2bNext.pcConst", 32'(fif.IfIdPc), 32'd12);

        // Redirect to the current PC refetches it
        applyStimulus(1'b0, 1'b1, 13, "selfRedir");

        // Async reset mid-run at PC = 7
        applyStimulus(1'b0, 1'b1, 6, "asyncSetup");
        applyStimulus(1'b0, 1'b0, 0, "asyncPrime");
        checkOutput("asyncPrime.addrConst", 32'(fif.ImemAddr), 32'd7);
        doAsyncReset("async");
        applyStimulus(1'b0, 1'b0, 0, "asyncAfter");
        checkOutput("asyncAfter.pcConst", 32'(fif.IfIdPc), 32'd0);

        // Randomized traffic with fresh memory contents
        for (int i = 0; i < PCMOD; i++) imem[i] = $urandom;
        for (int i = 0; i < 300; i++) begin
            logic st;
            logic rd;
            st = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 15);
            applyStimulus(st, rd, int'($urandom_range(0, PCMOD - 1)), "rnd");
            if ($urandom_range(0, 49) == 0) doAsyncReset("rndRst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
